// File: rtl/conv_mc_pkg.sv
// Shared types and elaboration helpers for the multi-channel convolution engine.
package conv_mc_pkg;

   // Engine control states.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      CONV   = 3'd2,
      WRITE  = 3'd3,
      DONE   = 3'd4
   } state_e;

   // Output feature-map edge for an n x n image, k x k kernel and stride s.
   function automatic int calc_ow(input int n, input int k, input int s);
      return (n - k) / s + 1;
   endfunction

   // Counter width able to hold 0..n-1 (never narrower than one bit).
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate fed by a read-latency-matched valid/weight pipeline.
// The weight travels alongside its read request so it meets the returning pixel.
module conv_mac #(
   parameter int DATA_BW   = 8,
   parameter int WEIGHT_BW = 8,
   parameter int SUM_BW    = 16,
   parameter int RD_LAT    = 1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        valid_i,
   input  logic                        clr_i,
   input  logic signed [WEIGHT_BW-1:0] weight_i,
   input  logic        [DATA_BW-1:0]   pix_i,
   output logic signed [SUM_BW-1:0]    acc_o
);

   localparam int PW = DATA_BW + WEIGHT_BW + 1;

   logic        [RD_LAT-1:0]    vld_q;
   logic signed [WEIGHT_BW-1:0] wgt_q [RD_LAT];
   logic signed [PW-1:0]        prod;
   logic signed [SUM_BW-1:0]    acc_q, acc_d;

   // Delay valid and weight by the BRAM read latency.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         for (int k = 0; k < RD_LAT; k++) wgt_q[k] <= '0;
         acc_q <= '0;
      end else begin
         vld_q[0] <= valid_i;
         wgt_q[0] <= weight_i;
         for (int k = 1; k < RD_LAT; k++) begin
            vld_q[k] <= vld_q[k-1];
            wgt_q[k] <= wgt_q[k-1];
         end
         acc_q <= acc_d;
      end
   end

   // Unsigned pixel times signed weight, accumulated modulo 2^SUM_BW.
   always_comb begin
      prod  = PW'($signed({1'b0, pix_i})) * PW'(wgt_q[RD_LAT-1]);
      acc_d = acc_q;
      if (clr_i)                  acc_d = '0;
      else if (vld_q[RD_LAT-1])   acc_d = acc_q + SUM_BW'(prod);
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/conv_engine_mc.sv
// Multi-channel convolution engine on BRAM port 1: loads CH*K*K weights,
// then computes one output map summed over channels, writing one word per pixel.
// Read handshake: o_r_en with o_r_addr issues a read; i_r_data holds that word
// exactly RD_LAT cycles later. A write happens in any cycle o_w_en is high.
module conv_engine_mc
   import conv_mc_pkg::*;
#(
   parameter int KERNEL_SIZE = 5,
   parameter int DATA_SIZE   = 32,
   parameter int STRIDE      = 1,
   parameter int CH          = 4,
   parameter int DATA_BW     = 8,
   parameter int WEIGHT_BW   = 8,
   parameter int SUM_BW      = 16,
   parameter int AXI_ADDR_BW = 32,
   parameter int AXI_DATA_BW = 32,
   parameter int IN_BASE     = 0,
   parameter int W_BASE      = 4096,
   parameter int OUT_BASE    = 8192,
   parameter int RD_LAT      = 1
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic                   i_w_done,
   input  logic                   i_relu,
   input  logic [AXI_DATA_BW-1:0] i_r_data,
   output logic [AXI_ADDR_BW-1:0] o_r_addr,
   output logic                   o_r_en,
   output logic [AXI_DATA_BW-1:0] o_w_data,
   output logic [AXI_ADDR_BW-1:0] o_w_addr,
   output logic                   o_w_en,
   output logic                   o_busy,
   output logic                   o_done,
   output state_e                 o_dbg_state
);

   localparam int OW   = calc_ow(DATA_SIZE, KERNEL_SIZE, STRIDE);
   localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
   localparam int TAPS = CH * KK;
   localparam int LAST = TAPS + RD_LAT - 1;
   localparam int CW   = cnt_w(TAPS + RD_LAT);
   localparam int TW   = cnt_w(TAPS);
   localparam int PW   = cnt_w(OW);
   localparam int KW   = cnt_w(KERNEL_SIZE);
   localparam int CHW  = cnt_w(CH);
   localparam int AB   = AXI_ADDR_BW;

   if (KERNEL_SIZE > DATA_SIZE) begin : g_bad_k
      $error("conv_engine_mc: KERNEL_SIZE must not exceed DATA_SIZE");
   end
   if (STRIDE < 1) begin : g_bad_s
      $error("conv_engine_mc: STRIDE must be at least 1");
   end
   if (RD_LAT < 1) begin : g_bad_lat
      $error("conv_engine_mc: RD_LAT must be at least 1");
   end

   state_e                      state_q, state_d;
   logic                        wd_q, relu_q, relu_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [CHW-1:0]              c_q, c_d;
   logic [KW-1:0]               i_q, i_d, j_q, j_d;
   logic [PW-1:0]               ox_q, ox_d, oy_q, oy_d;
   logic signed [WEIGHT_BW-1:0] wgt_q [TAPS];
   logic                        wgt_we;
   logic [TW-1:0]               wgt_idx;
   logic                        mac_vld, mac_clr;
   logic signed [WEIGHT_BW-1:0] mac_w;
   logic signed [SUM_BW-1:0]    acc;
   logic [AB-1:0]               in_addr;
   logic                        unused_rdata;

   assign unused_rdata = ^i_r_data;
   assign o_dbg_state  = state_q;

   // State, counters, start-edge history and the weight register file.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         wd_q    <= 1'b0;
         relu_q  <= 1'b0;
         cnt_q   <= '0;
         c_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         for (int t = 0; t < TAPS; t++) wgt_q[t] <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= i_w_done;
         relu_q  <= relu_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         i_q     <= i_d;
         j_q     <= j_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         if (wgt_we) wgt_q[wgt_idx] <= i_r_data[WEIGHT_BW-1:0];
      end
   end

   // Pixel address of tap (c, i, j) for the current output pixel.
   always_comb begin
      in_addr = AB'(IN_BASE) + AB'(c_q) * AB'(DATA_SIZE * DATA_SIZE)
              + (AB'(oy_q) * AB'(STRIDE) + AB'(i_q)) * AB'(DATA_SIZE)
              + AB'(ox_q) * AB'(STRIDE) + AB'(j_q);
   end

   // Next-state logic and all BRAM/status outputs.
   always_comb begin
      state_d  = state_q;
      relu_d   = relu_q;
      cnt_d    = cnt_q;
      c_d      = c_q;
      i_d      = i_q;
      j_d      = j_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      o_r_en   = 1'b0;
      o_r_addr = '0;
      o_w_en   = 1'b0;
      o_w_addr = '0;
      o_w_data = '0;
      o_busy   = 1'b0;
      o_done   = 1'b0;
      wgt_we   = 1'b0;
      wgt_idx  = '0;
      mac_vld  = 1'b0;
      mac_clr  = 1'b0;
      mac_w    = '0;
      case (state_q)
         IDLE: begin
            if (i_w_done && !wd_q) begin
               state_d = LOAD_W;
               relu_d  = i_relu;
               cnt_d   = '0;
               c_d     = '0;
               i_d     = '0;
               j_d     = '0;
               ox_d    = '0;
               oy_d    = '0;
               mac_clr = 1'b1;
            end
         end
         LOAD_W: begin
            o_busy = 1'b1;
            if (cnt_q < CW'(TAPS)) begin
               o_r_en   = 1'b1;
               o_r_addr = AB'(W_BASE) + AB'(cnt_q);
            end
            if (cnt_q >= CW'(RD_LAT)) begin
               wgt_we  = 1'b1;
               wgt_idx = TW'(cnt_q - CW'(RD_LAT));
            end
            if (cnt_q == CW'(LAST)) begin
               state_d = CONV;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         CONV: begin
            o_busy = 1'b1;
            if (cnt_q < CW'(TAPS)) begin
               o_r_en   = 1'b1;
               o_r_addr = in_addr;
               mac_vld  = 1'b1;
               mac_w    = wgt_q[TW'(cnt_q)];
               // taps ordered c, i, j; the triple wraps to zero after TAPS reads
               if (j_q == KW'(KERNEL_SIZE - 1)) begin
                  j_d = '0;
                  if (i_q == KW'(KERNEL_SIZE - 1)) begin
                     i_d = '0;
                     c_d = (c_q == CHW'(CH - 1)) ? '0 : c_q + CHW'(1);
                  end else begin
                     i_d = i_q + KW'(1);
                  end
               end else begin
                  j_d = j_q + KW'(1);
               end
            end
            if (cnt_q == CW'(LAST)) begin
               state_d = WRITE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WRITE: begin
            o_busy   = 1'b1;
            o_w_en   = 1'b1;
            o_w_addr = AB'(OUT_BASE) + AB'(oy_q) * AB'(OW) + AB'(ox_q);
            o_w_data = (relu_q && acc[SUM_BW-1]) ? '0 : AXI_DATA_BW'(acc);
            mac_clr  = 1'b1;
            if (ox_q == PW'(OW - 1)) begin
               ox_d = '0;
               oy_d = oy_q + PW'(1);
            end else begin
               ox_d = ox_q + PW'(1);
            end
            state_d = (ox_q == PW'(OW - 1) && oy_q == PW'(OW - 1)) ? DONE : CONV;
         end
         DONE: begin
            o_done = 1'b1;
            if (!i_w_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   conv_mac #(
      .DATA_BW  (DATA_BW),
      .WEIGHT_BW(WEIGHT_BW),
      .SUM_BW   (SUM_BW),
      .RD_LAT   (RD_LAT)
   ) u_mac (
      .clk_i   (ACLK),
      .rst_ni  (ARESETn),
      .valid_i (mac_vld),
      .clr_i   (mac_clr),
      .weight_i(mac_w),
      .pix_i   (i_r_data[DATA_BW-1:0]),
      .acc_o   (acc)
   );

endmodule

// File: tb/tb_conv_engine_mc.sv
// Bench for conv_engine_mc: two instances (stride 1 and stride 2) share one
// BRAM model; results are checked against a loop-based convolution model.
module tb_conv_engine_mc;
   import conv_mc_pkg::*;

   localparam int N        = 6;
   localparam int K        = 3;
   localparam int CH       = 2;
   localparam int TAPS     = CH * K * K;
   localparam int W_BASE   = 4096;
   localparam int OUT_BASE = 8192;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, wd_a, wd_b, relu;
   logic [31:0] rdata;
   logic [31:0] a_r_addr, a_w_data, a_w_addr, b_r_addr, b_w_data, b_w_addr;
   logic        a_r_en, a_w_en, a_busy, a_done, b_r_en, b_w_en, b_busy, b_done;
   state_e      a_state, b_state;

   conv_engine_mc #(.KERNEL_SIZE(K), .DATA_SIZE(N), .STRIDE(1), .CH(CH)) dut_a (
      .ACLK(clk), .ARESETn(rst_n), .i_w_done(wd_a), .i_relu(relu), .i_r_data(rdata),
      .o_r_addr(a_r_addr), .o_r_en(a_r_en), .o_w_data(a_w_data), .o_w_addr(a_w_addr),
      .o_w_en(a_w_en), .o_busy(a_busy), .o_done(a_done), .o_dbg_state(a_state));

   conv_engine_mc #(.KERNEL_SIZE(K), .DATA_SIZE(N), .STRIDE(2), .CH(CH)) dut_b (
      .ACLK(clk), .ARESETn(rst_n), .i_w_done(wd_b), .i_relu(relu), .i_r_data(rdata),
      .o_r_addr(b_r_addr), .o_r_en(b_r_en), .o_w_data(b_w_data), .o_w_addr(b_w_addr),
      .o_w_en(b_w_en), .o_busy(b_busy), .o_done(b_done), .o_dbg_state(b_state));

   // BRAM model: request sampled mid-cycle, data presented after the next edge
   logic [31:0] mem [0:16383];
   logic        r_pend;
   logic [31:0] r_addr;
   logic [31:0] log_addr_q [$];
   logic [31:0] log_data_q [$];
   int          log_src_q  [$];
   int          overlap = 0;
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q [$];

   always @(negedge clk) begin
      r_pend <= a_r_en | b_r_en;
      r_addr <= a_r_en ? a_r_addr : b_r_addr;
      if (a_w_en) begin
         log_addr_q.push_back(a_w_addr); log_data_q.push_back(a_w_data); log_src_q.push_back(0);
      end
      if (b_w_en) begin
         log_addr_q.push_back(b_w_addr); log_data_q.push_back(b_w_data); log_src_q.push_back(1);
      end
      if ((a_r_en && a_w_en) || (b_r_en && b_w_en)) overlap++;
   end

   always @(posedge clk) if (r_pend) rdata <= mem[r_addr[13:0]];

   // scoreboard compare
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // reference model: direct convolution of the memory image
   task automatic build_exp(input int stride, input bit rl);
      int ow, sum;
      logic        [7:0]  p;
      logic signed [7:0]  w;
      logic signed [15:0] s16;
      exp_q.delete();
      ow = (N - K) / stride + 1;
      for (int oy = 0; oy < ow; oy++)
         for (int ox = 0; ox < ow; ox++) begin
            sum = 0;
            for (int c = 0; c < CH; c++)
               for (int i = 0; i < K; i++)
                  for (int j = 0; j < K; j++) begin
                     p = mem[c*N*N + (oy*stride + i)*N + ox*stride + j][7:0];
                     w = mem[W_BASE + c*K*K + i*K + j][7:0];
                     sum += int'(p) * int'(w);
                  end
            s16 = sum[15:0];
            exp_q.push_back((rl && s16 < 0) ? 32'h0 : {{16{s16[15]}}, s16});
         end
   endtask

   // driver tasks
   task automatic fill(input bit rnd, input logic [7:0] pv, input logic [7:0] wv);
      logic [31:0] r;
      for (int a = 0; a < CH*N*N; a++) begin
         r = $urandom();
         mem[a] = {r[31:8], rnd ? r[7:0] : pv};
      end
      for (int a = 0; a < TAPS; a++) begin
         r = $urandom();
         mem[W_BASE + a] = {r[31:8], rnd ? r[15:8] : wv};
      end
   endtask

   task automatic set_wd(input int sel, input logic v);
      if (sel == 0) wd_a = v; else wd_b = v;
   endtask

   function automatic logic busy_of(input int sel);
      return (sel == 0) ? a_busy : b_busy;
   endfunction

   function automatic logic done_of(input int sel);
      return (sel == 0) ? a_done : b_done;
   endfunction

   task automatic run_case(input int sel, input bit rl, input int glitch, input int hold,
                           input bit has_lit, input logic [31:0] lit);
      int stride, ow, exp_cyc, base, n, cnt;
      logic [31:0] e;
      stride  = (sel == 0) ? 1 : 2;
      ow      = (N - K) / stride + 1;
      exp_cyc = (TAPS + 1) + ow*ow*(TAPS + 2) + 1;
      build_exp(stride, rl);
      base = log_data_q.size();
      @(negedge clk);
      relu = rl;
      set_wd(sel, 1'b1);
      #1 check("busy_in_start_cycle", {31'b0, busy_of(sel)}, 32'd0);
      n = 0;
      for (int k = 1; k <= 4000 && n == 0; k++) begin
         @(posedge clk); #1;
         if (k == 1) check("busy_after_start", {31'b0, busy_of(sel)}, 32'd1);
         if (glitch != 0 && k == glitch) set_wd(sel, 1'b0);
         if (glitch != 0 && k == glitch + 2) set_wd(sel, 1'b1);
         if (done_of(sel)) n = k;
      end
      check("done_latency", n, exp_cyc);
      check("busy_at_done", {31'b0, busy_of(sel)}, 32'd0);
      cnt = log_data_q.size() - base;
      check("write_count", cnt, exp_q.size());
      for (int i = 0; i < cnt && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         check("write_addr", log_addr_q[base+i], OUT_BASE + i);
         check("write_data", log_data_q[base+i], e);
         check("write_src", log_src_q[base+i], sel);
         if (has_lit) check("write_data_lit", log_data_q[base+i], lit);
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("done_held", {31'b0, done_of(sel)}, 32'd1);
      end
      @(negedge clk);
      set_wd(sel, 1'b0);
      @(posedge clk); #1;
      check("done_cleared", {31'b0, done_of(sel)}, 32'd0);
   endtask

   initial begin
      int base;
      for (int a = 0; a < 16384; a++) mem[a] = 32'h0;
      rst_n = 1'b0; wd_a = 1'b0; wd_b = 1'b0; relu = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'b0, a_busy}, 32'd0);
      check("rst_done", {31'b0, a_done}, 32'd0);
      check("rst_r_en", {31'b0, a_r_en}, 32'd0);
      check("rst_w_en", {31'b0, a_w_en}, 32'd0);
      check("rst_r_addr", a_r_addr, 32'd0);
      check("rst_w_data", a_w_data, 32'd0);
      check("rst_state", {29'b0, a_state}, {29'b0, IDLE});
      check("rst_b_done", {31'b0, b_done}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // all-ones data, stride 1 then with done held, then stride 2
      fill(1'b0, 8'd1, 8'd1);
      run_case(0, 1'b0, 0, 0, 1'b1, 32'h0000_0012);
      run_case(0, 1'b0, 0, 8, 1'b1, 32'h0000_0012);
      run_case(1, 1'b0, 0, 0, 1'b1, 32'h0000_0012);

      // negative weights with and without ReLU
      fill(1'b0, 8'd1, 8'hFF);
      run_case(0, 1'b0, 0, 0, 1'b1, 32'hFFFF_FFEE);
      run_case(0, 1'b1, 0, 0, 1'b1, 32'h0000_0000);

      // accumulator wrap
      fill(1'b0, 8'd255, 8'd127);
      run_case(0, 1'b0, 0, 0, 1'b1, 32'hFFFF_E512);
      run_case(1, 1'b0, 0, 0, 1'b1, 32'hFFFF_E512);

      // start edge toggled during CONV must be ignored
      fill(1'b0, 8'd1, 8'd1);
      run_case(0, 1'b0, 60, 0, 1'b1, 32'h0000_0012);

      // random images and weights
      for (int r = 0; r < 3; r++) begin
         fill(1'b1, 8'd0, 8'd0);
         run_case(r % 2, 1'($urandom_range(0, 1)), 0, 0, 1'b0, 32'h0);
      end

      // reset in the middle of CONV
      fill(1'b0, 8'd1, 8'd1);
      @(negedge clk) wd_a = 1'b1;
      repeat (60) @(negedge clk);
      check("busy_before_reset", {31'b0, a_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'b0, a_busy}, 32'd0);
      check("mid_rst_r_en", {31'b0, a_r_en}, 32'd0);
      check("mid_rst_w_en", {31'b0, a_w_en}, 32'd0);
      check("mid_rst_r_addr", a_r_addr, 32'd0);
      check("mid_rst_w_addr", a_w_addr, 32'd0);
      check("mid_rst_w_data", a_w_data, 32'd0);
      check("mid_rst_done", {31'b0, a_done}, 32'd0);
      base = log_data_q.size();
      wd_a = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("no_write_after_reset", log_data_q.size() - base, 32'd0);
      run_case(0, 1'b0, 0, 0, 1'b1, 32'h0000_0012);

      check("rd_wr_overlap", overlap, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
